muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand width; HiLoWrite is 2*WIDTH.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request a multiply/divide; sampled only in IDLE.
REQ-005 Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 A  input  WIDTH  multiplicand/dividend (rs value).
REQ-007 B  input  WIDTH  multiplier/divisor (rs/rt or immediate path).
REQ-008 Busy  output  1  high while an operation is in progress.
REQ-009 Stall  output  1  hold PC and pipeline; equals Start-in-IDLE OR Busy (combinational).
REQ-010 HiLoEn  output  1  one-cycle write enable to the Hi/Lo register.
REQ-011 HiLoWrite  output  2*WIDTH  {Hi, Lo} result, valid only while HiLoEn=1.
REQ-012 DivByZero  output  1  one-cycle flag, coincident with HiLoEn, for divide with B=0.

Function
REQ-013 FSM states: IDLE, RUN, WRITE.
REQ-014 IDLE: Start=1 -> latch Op, operand magnitudes, result signs; load iteration counter with WIDTH; go to RUN.
REQ-015 IDLE, divide with B=0: go directly to WRITE; no RUN cycles.
REQ-016 RUN: perform one iteration per cycle (shift-add multiply, restoring divide); counter decrements; after the WIDTH-th iteration go to WRITE.
REQ-017 WRITE: HiLoEn=1 for exactly one cycle; apply sign correction; return to IDLE.
REQ-018 Latency: HiLoEn asserted on cycle WIDTH+1 after the Start-sampling edge (33 for WIDTH=32); 1 cycle for divide by zero.
REQ-019 Busy=1 in RUN and WRITE; 0 in IDLE.
REQ-020 Back-to-back: Start may be accepted in the cycle after WRITE (IDLE); no mandatory idle gap beyond that.
REQ-021 Start, Op, A and B are ignored while Busy=1; operands used are those captured at acceptance.
REQ-022 MULT/MULTU: HiLoWrite = full 2*WIDTH product, signed or unsigned per Op.
REQ-023 DIV/DIVU: Hi = remainder, Lo = quotient; signed divide truncates toward zero.
REQ-024 Signed divide: quotient negative iff sign(A) XOR sign(B); remainder takes sign of A.
REQ-025 Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0, no flag.
REQ-026 Divide by zero (either divide Op): Hi=A, Lo=all ones, DivByZero=1 with HiLoEn.
REQ-027 Simultaneous Start and Rst: Rst wins; operation not accepted.

Reset
REQ-028 Rst=1 at any edge forces IDLE; all outputs Busy, HiLoEn, DivByZero=0 and HiLoWrite=0 the following cycle.
REQ-029 Rst asserted during RUN aborts the operation; no HiLoEn is issued for it.
REQ-030 Internal counter and accumulators clear to zero on reset.

Structure
REQ-031 Shared package muldiv_pkg holds Op encodings, FSM state encoding and default WIDTH.
REQ-032 One sub-module, muldiv_step: combinational single-iteration (add/subtract-shift), instantiated once; FSM and sign handling stay in muldiv_sequencer.
REQ-033 No multiplier or divider primitives inferred; iteration hardware only.

Verification
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HiLoWrite=0xFFFFFFFE_00000001, HiLoEn on cycle 33.
REQ-035 MULT A=-3 (0xFFFFFFFD), B=7 -> HiLoWrite=0xFFFFFFFF_FFFFFFEB; Stall high from Start cycle until the cycle after HiLoEn.
REQ-036 DIV A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-037 DIVU A=0x1234, B=0 -> HiLoEn and DivByZero one cycle after Start; Hi=0x1234, Lo=0xFFFFFFFF.
REQ-038 Start MULTU 5x6, assert Rst at RUN cycle 10 -> no HiLoEn; Busy=0 next cycle; new Start 2x3 -> HiLoWrite=6.
REQ-039 Start toggled with changed A/B during RUN -> ignored; result matches operands captured at acceptance; next Start accepted the cycle after WRITE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide sequencer:
//   - DEFAULT_WIDTH : default operand width
//   - op_e          : operation encoding on the op bus
//   - state_e       : sequencer FSM state encoding
//   - isDivideOp / isSignedOp : small decode helpers for op_e
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    function automatic logic isDivideOp(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Request/response bundle between the pipeline (master) and the
// multiply/divide sequencer (slave).
//   start      : request an operation (master -> slave)
//   op         : operation select, op_e (master -> slave)
//   a, b       : operands (master -> slave)
//   busy       : operation in progress (slave -> master)
//   stall      : hold PC and pipeline (slave -> master)
//   hiLoEn     : one-cycle Hi/Lo write enable (slave -> master)
//   hiLoWrite  : {Hi, Lo} result, valid with hiLoEn (slave -> master)
//   divByZero  : divide-by-zero flag, valid with hiLoEn (slave -> master)
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic               start;
    op_e                op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               stall;
    logic               hiLoEn;
    logic [2*WIDTH-1:0] hiLoWrite;
    logic               divByZero;

    modport master (
        output start, op, a, b,
        input  busy, stall, hiLoEn, hiLoWrite, divByZero
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall, hiLoEn, hiLoWrite, divByZero
    );

endinterface

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of an unsigned shift-add multiply or a
// restoring divide, operating on a {hi, lo} register pair.
//   i_isDiv   : 1 = divide step, 0 = multiply step
//   i_hi      : multiply: partial product high half / divide: partial remainder
//   i_lo      : multiply: multiplier bits (shifting out) / divide: dividend
//               bits shifting out, quotient bits shifting in
//   i_operand : multiply: multiplicand magnitude / divide: divisor magnitude
//   o_hi/o_lo : register pair after this iteration
// ---------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shiftRem;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the carry, sum and multiplier right by one.
    // Divide: shift the next dividend bit into the remainder and subtract
    // the divisor only if it fits. The remainder is always below the divisor
    // before the shift, so a fitting difference always fits in WIDTH bits.
    always_comb begin
        w_addend   = i_lo[0] ? {1'b0, i_operand} : '0;
        w_sum      = {1'b0, i_hi} + w_addend;
        w_shiftRem = {i_hi, i_lo[WIDTH-1]};
        w_fits     = (w_shiftRem >= {1'b0, i_operand});
        w_diff     = w_shiftRem[WIDTH-1:0] - i_operand;
        if (i_isDiv) begin
            o_hi = w_fits ? w_diff : w_shiftRem[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_fits};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative signed/unsigned multiply and divide producing a {Hi, Lo} write.
// Operands are reduced to magnitudes on acceptance, WIDTH iterations of
// muldiv_step run one per cycle, and signs are restored in the WRITE cycle.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : muldiv_sequencer_if.slave (start/op/a/b in, busy/stall/hiLoEn/
//           hiLoWrite/divByZero out)
// ---------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    muldiv_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_nextState;
    logic [CW-1:0]      r_count;
    logic               r_isDiv;
    logic               r_negLo;
    logic               r_negHi;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_operand;

    logic               w_accept;
    logic               w_opDiv;
    logic               w_negA;
    logic               w_negB;
    logic               w_bZero;
    logic               w_busy;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH-1:0]   w_stepHi;
    logic [WIDTH-1:0]   w_stepLo;
    logic [2*WIDTH-1:0] w_prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_isDiv   (r_isDiv),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .i_operand (r_operand),
        .o_hi      (w_stepHi),
        .o_lo      (w_stepLo)
    );

    // Request decode. The most negative value negates to itself, which is
    // exactly its unsigned magnitude, so no special case is needed for it.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && bus.start;
        w_opDiv  = isDivideOp(bus.op);
        w_negA   = isSignedOp(bus.op) && bus.a[WIDTH-1];
        w_negB   = isSignedOp(bus.op) && bus.b[WIDTH-1];
        w_magA   = w_negA ? -bus.a : bus.a;
        w_magB   = w_negB ? -bus.b : bus.b;
        w_bZero  = (bus.b == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A divide by zero skips RUN entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_nextState = (w_opDiv && w_bZero) ? ST_WRITE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_count == CW'(1)) begin
                    w_nextState = ST_WRITE;
                end
            end
            ST_WRITE: w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Datapath. Multiply keeps the multiplier in lo and the multiplicand in
    // r_operand; divide keeps the dividend in lo and the divisor in
    // r_operand. A divide by zero preloads the final {A, all ones} result
    // with no sign correction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negLo   <= 1'b0;
            r_negHi   <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_operand <= '0;
        end else if (w_accept) begin
            r_isDiv <= w_opDiv;
            r_count <= CW'(WIDTH);
            if (w_opDiv && w_bZero) begin
                r_hi      <= bus.a;
                r_lo      <= '1;
                r_operand <= '0;
                r_negLo   <= 1'b0;
                r_negHi   <= 1'b0;
                r_divZero <= 1'b1;
            end else if (w_opDiv) begin
                r_hi      <= '0;
                r_lo      <= w_magA;
                r_operand <= w_magB;
                r_negLo   <= w_negA ^ w_negB;
                r_negHi   <= w_negA;
                r_divZero <= 1'b0;
            end else begin
                r_hi      <= '0;
                r_lo      <= w_magB;
                r_operand <= w_magA;
                r_negLo   <= w_negA ^ w_negB;
                r_negHi   <= w_negA ^ w_negB;
                r_divZero <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            r_hi    <= w_stepHi;
            r_lo    <= w_stepLo;
            r_count <= r_count - CW'(1);
        end
    end

    // Outputs. A product is negated as one 2*WIDTH value; quotient and
    // remainder are negated independently. hiLoWrite is forced to zero
    // outside WRITE.
    always_comb begin
        w_prod        = {r_hi, r_lo};
        w_busy        = (r_state != ST_IDLE);
        bus.busy      = w_busy;
        bus.stall     = w_accept || w_busy;
        bus.hiLoEn    = (r_state == ST_WRITE);
        bus.divByZero = (r_state == ST_WRITE) && r_divZero;
        bus.hiLoWrite = '0;
        if (r_state == ST_WRITE) begin
            if (r_isDiv) begin
                bus.hiLoWrite = {(r_negHi ? -r_hi : r_hi), (r_negLo ? -r_lo : r_lo)};
            end else begin
                bus.hiLoWrite = r_negLo ? -w_prod : w_prod;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed-vector bench for muldiv_sequencer with hand-computed results.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expected;
        logic        expDz;
        int          expLatency;
    } vector_t;

    logic    clk = 1'b0;
    logic    rst;
    int      checkCount = 0;
    int      errorCount = 0;
    vector_t vectors[10];

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Presents a request for one cycle; returns at the negedge of cycle 1
    // (the first cycle after the sampling edge) with start released.
    task automatic applyStimulus(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        checkOutput({tag, ".stallStart"}, {63'd0, bus.stall}, 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for hiLoEn, counting cycles from startCycle.
    task automatic waitForWrite(input int startCycle, output int latency, output logic [63:0] data,
                                output logic dz, output logic stallHeld);
        latency   = startCycle;
        stallHeld = 1'b1;
        while (bus.hiLoEn !== 1'b1 && latency < 100) begin
            if (bus.stall !== 1'b1) stallHeld = 1'b0;
            @(negedge clk);
            latency++;
        end
        if (bus.stall !== 1'b1) stallHeld = 1'b0;
        data = bus.hiLoWrite;
        dz   = bus.divByZero;
    endtask

    initial begin
        int          latency;
        logic [63:0] data;
        logic        dz;
        logic        stallHeld;
        logic        sawEn;
        string       tag;

        vectors[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 33};
        vectors[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 33};
        vectors[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33};
        vectors[3] = '{OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 33};
        vectors[4] = '{OP_DIVU,  32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF, 1'b1, 1};
        vectors[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33};
        vectors[6] = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 64'h00000000_0000001E, 1'b0, 33};
        vectors[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33};
        vectors[8] = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 1};
        vectors[9] = '{OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 33};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy",      {63'd0, bus.busy},      64'd0);
        checkOutput("reset.stall",     {63'd0, bus.stall},     64'd0);
        checkOutput("reset.hiLoEn",    {63'd0, bus.hiLoEn},    64'd0);
        checkOutput("reset.divByZero", {63'd0, bus.divByZero}, 64'd0);
        checkOutput("reset.hiLoWrite", bus.hiLoWrite,          64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("v%0d", i);
            applyStimulus(tag, vectors[i].op, vectors[i].a, vectors[i].b);
            waitForWrite(1, latency, data, dz, stallHeld);
            checkOutput({tag, ".latency"},   64'(latency),       64'(vectors[i].expLatency));
            checkOutput({tag, ".hiLoWrite"}, data,               vectors[i].expected);
            checkOutput({tag, ".divByZero"}, {63'd0, dz},        {63'd0, vectors[i].expDz});
            checkOutput({tag, ".stallHeld"}, {63'd0, stallHeld}, 64'd1);
            @(negedge clk);
            checkOutput({tag, ".busyAfter"},  {63'd0, bus.busy},   64'd0);
            checkOutput({tag, ".stallAfter"}, {63'd0, bus.stall},  64'd0);
            checkOutput({tag, ".enAfter"},    {63'd0, bus.hiLoEn}, 64'd0);
        end

        // Abort: reset during the tenth RUN cycle.
        applyStimulus("abort", OP_MULTU, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort.busy",      {63'd0, bus.busy},   64'd0);
        checkOutput("abort.hiLoEn",    {63'd0, bus.hiLoEn}, 64'd0);
        checkOutput("abort.hiLoWrite", bus.hiLoWrite,       64'd0);
        rst   = 1'b0;
        sawEn = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.hiLoEn === 1'b1) sawEn = 1'b1;
        end
        checkOutput("abort.noWrite", {63'd0, sawEn}, 64'd0);
        applyStimulus("afterAbort", OP_MULTU, 32'd2, 32'd3);
        waitForWrite(1, latency, data, dz, stallHeld);
        checkOutput("afterAbort.latency",   64'(latency), 64'd33);
        checkOutput("afterAbort.hiLoWrite", data,         64'd6);
        @(negedge clk);

        // Reset and start together: reset wins.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        checkOutput("rstWins.busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        checkOutput("rstWins.busyLater", {63'd0, bus.busy}, 64'd0);

        // Start held high with new operands during RUN is ignored, then
        // accepted in the idle cycle right after WRITE.
        applyStimulus("ignore", OP_MULTU, 32'd10, 32'd20);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd99;
        bus.b     = 32'd99;
        waitForWrite(5, latency, data, dz, stallHeld);
        checkOutput("ignore.latency",   64'(latency), 64'd33);
        checkOutput("ignore.hiLoWrite", data,         64'd200);
        @(negedge clk);
        checkOutput("backToBack.idleBusy",  {63'd0, bus.busy},  64'd0);
        checkOutput("backToBack.idleStall", {63'd0, bus.stall}, 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        waitForWrite(1, latency, data, dz, stallHeld);
        checkOutput("backToBack.latency",   64'(latency), 64'd33);
        checkOutput("backToBack.hiLoWrite", data,         64'h00000000_00000001);
        checkOutput("backToBack.divByZero", {63'd0, dz},  64'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
